// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rxd, mid-bit sampling, optional parity and
// one/two stop bits, single-entry AXI-Stream output register with error pulses.
module uart_rx #(
    parameter int unsigned BAUD_PRESCALER = 12,
    parameter int unsigned PARITY         = 0,
    parameter int unsigned WORD_SIZE      = 8,
    parameter int unsigned STOP_BITS      = 0
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 rxd,
    output logic                 rtsn,
    output logic [WORD_SIZE-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    input  logic [15:0]          prescaler_config,
    input  logic [2:0]           parity_config,
    input  logic                 stop_bits_config
);

    localparam int unsigned CW = 16;
    localparam int unsigned BW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic                 rx_prev_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_q;
    logic [WORD_SIZE-1:0] shift_q;
    logic [CW-1:0]        pscl_q;
    logic [2:0]           par_cfg_q;
    logic                 stop_cfg_q;
    logic                 par_pend_q;
    logic                 frm_pend_q;
    logic [WORD_SIZE-1:0] tdata_q;
    logic                 tvalid_q;
    logic                 rtsn_q;
    logic                 busy_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 oerr_q;

    logic                 rx_s;
    logic [CW-1:0]        p_eff;
    logic [CW-1:0]        limit;
    logic                 tick;
    logic                 par_en;
    logic                 exp_par;
    logic                 drain;
    logic                 load;
    logic                 tvalid_d;

    assign rx_s = sync_q[1];

    // Bit timing, parity expectation and output-register handshake
    always_comb begin
        p_eff    = (pscl_q < CW'(2)) ? CW'(2) : pscl_q;
        limit    = (state_q == S_START) ? (p_eff >> 1) : p_eff;
        tick     = (cnt_q == CW'(limit - CW'(1)));
        par_en   = (par_cfg_q >= 3'd1) && (par_cfg_q <= 3'd4);
        exp_par  = 1'b0;
        case (par_cfg_q)
            3'd1:    exp_par = ^shift_q;
            3'd2:    exp_par = ~(^shift_q);
            3'd3:    exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
        drain    = tvalid_q & m_axis_tready;
        load     = (state_q == S_DONE) && (!tvalid_q || drain);
        tvalid_d = load | (tvalid_q & ~m_axis_tready);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            pscl_q     <= CW'(BAUD_PRESCALER);
            par_cfg_q  <= 3'(PARITY);
            stop_cfg_q <= 1'(STOP_BITS);
            par_pend_q <= 1'b0;
            frm_pend_q <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            rtsn_q     <= 1'b0;
            busy_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            oerr_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rxd};
            // Forcing "previous high" after DONE lets a start edge arriving in DONE still count
            rx_prev_q <= (state_q == S_DONE) ? 1'b1 : rx_s;
            tvalid_q  <= tvalid_d;
            rtsn_q    <= tvalid_d;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;
            busy_q    <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    pscl_q     <= prescaler_config;
                    par_cfg_q  <= parity_config;
                    stop_cfg_q <= stop_bits_config;
                    cnt_q      <= '0;
                    bit_q      <= '0;
                    par_pend_q <= 1'b0;
                    frm_pend_q <= 1'b0;
                    busy_q     <= !rx_s && rx_prev_q;
                    if (!rx_s && rx_prev_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        busy_q  <= !rx_s;
                        state_q <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[WORD_SIZE-1:1]};
                        if (bit_q == BW'(WORD_SIZE - 1)) begin
                            bit_q   <= '0;
                            state_q <= par_en ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        state_q <= S_STOP;
                        if (rx_s != exp_par) begin
                            par_pend_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            frm_pend_q <= 1'b1;
                        end
                        if (bit_q == BW'(stop_cfg_q)) begin
                            state_q <= S_DONE;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    perr_q  <= par_pend_q;
                    ferr_q  <= frm_pend_q;
                    oerr_q  <= !load;
                    if (load) begin
                        tdata_q <= shift_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign rtsn          = rtsn_q;
    assign busy          = busy_q;
    assign parity_err    = perr_q;
    assign frame_err     = ferr_q;
    assign overrun_err   = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are built bit-by-bit from the line protocol
// and delivered words / error pulses are compared against a queue-based model.
module tb_uart_rx;

    localparam int unsigned W = 8;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         rxd = 1'b1;
    logic         m_axis_tready = 1'b1;
    logic [15:0]  prescaler_config = 16'd16;
    logic [2:0]   parity_config = 3'd0;
    logic         stop_bits_config = 1'b0;
    logic         rtsn;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         busy;
    logic         parity_err;
    logic         frame_err;
    logic         overrun_err;

    uart_rx #(
        .BAUD_PRESCALER(12),
        .PARITY        (0),
        .WORD_SIZE     (W),
        .STOP_BITS     (0)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .rxd             (rxd),
        .rtsn            (rtsn),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .busy            (busy),
        .parity_err      (parity_err),
        .frame_err       (frame_err),
        .overrun_err     (overrun_err),
        .prescaler_config(prescaler_config),
        .parity_config   (parity_config),
        .stop_bits_config(stop_bits_config)
    );

    always #5 aclk = ~aclk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [W-1:0] exp_q[$];
    int unsigned  exp_perr = 0, exp_ferr = 0, exp_ovr = 0;
    int unsigned  seen_perr = 0, seen_ferr = 0, seen_ovr = 0, n_beats = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every accepted beat must match the oldest expected word
    always @(negedge aclk) begin
        if (aresetn) begin
            if (parity_err)  seen_perr++;
            if (frame_err)   seen_ferr++;
            if (overrun_err) seen_ovr++;
            if (m_axis_tvalid && m_axis_tready) begin
                n_beats++;
                check("rtsn_on_beat", 32'(rtsn), 32'd1);
                if (exp_q.size() == 0) check("spurious_beat", 32'd1, 32'd0);
                else                   check("tdata", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive_bit(input logic b, input int n);
        @(posedge aclk);
        #1;
        rxd = b;
        repeat (n - 1) @(posedge aclk);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input int p, input int par, input int stops,
                              input bit bad_par, input bit bad_stop);
        logic pb;
        prescaler_config = 16'(p);
        parity_config    = 3'(par);
        stop_bits_config = 1'(stops);
        drive_bit(1'b0, p);
        @(negedge aclk);
        check("busy_mid_frame", 32'(busy), 32'd1);
        for (int i = 0; i < int'(W); i++) drive_bit(d[i], p);
        if (par != 0) begin
            case (par)
                1:       pb = ^d;
                2:       pb = ~(^d);
                3:       pb = 1'b1;
                default: pb = 1'b0;
            endcase
            drive_bit(pb ^ bad_par, p);
            if (bad_par) exp_perr++;
        end
        // Model update before the stop bits: the word is handed off mid-stop-bit
        if (!m_axis_tready && exp_q.size() > 0) exp_ovr++;
        else                                    exp_q.push_back(d);
        if (bad_stop) exp_ferr++;
        drive_bit(!bad_stop, p);
        if (stops != 0) drive_bit(1'b1, p);
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_rtsn", 32'(rtsn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        idle(10);

        // 8N1 basic word
        send_frame(8'hA5, 16, 0, 0, 1'b0, 1'b0);
        idle(40);
        check("8n1_beats", n_beats, 32'd1);
        check("8n1_busy_after", 32'(busy), 32'd0);
        check("8n1_no_err", seen_perr + seen_ferr + seen_ovr, 32'd0);

        // Even parity with wrong parity bit
        send_frame(8'h03, 16, 1, 0, 1'b1, 1'b0);
        idle(40);
        check("bad_parity_pulses", seen_perr, exp_perr);

        // Bad stop bit, then a clean frame to prove resynchronization
        send_frame(8'h5A, 16, 0, 0, 1'b0, 1'b1);
        idle(40);
        check("bad_stop_pulses", seen_ferr, exp_ferr);
        send_frame(8'h96, 16, 0, 0, 1'b0, 1'b0);
        idle(40);
        check("resync_beats", n_beats, 32'd4);

        // Three-cycle glitch must be rejected silently
        drive_bit(1'b0, 3);
        idle(60);
        check("glitch_beats", n_beats, 32'd4);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("glitch_errs", seen_perr + seen_ferr + seen_ovr, exp_perr + exp_ferr + exp_ovr);

        // Overrun: consumer stalled across two frames
        m_axis_tready = 1'b0;
        send_frame(8'h11, 16, 0, 0, 1'b0, 1'b0);
        idle(40);
        send_frame(8'h22, 16, 0, 0, 1'b0, 1'b0);
        idle(40);
        @(negedge aclk);
        check("ovr_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("ovr_tdata", 32'(m_axis_tdata), 32'h11);
        check("ovr_rtsn", 32'(rtsn), 32'd1);
        check("ovr_pulses", seen_ovr, exp_ovr);
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        idle(5);
        @(negedge aclk);
        check("ovr_drained_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("ovr_drained_rtsn", 32'(rtsn), 32'd0);

        // Back-to-back single-stop frames
        send_frame(8'hC3, 16, 0, 0, 1'b0, 1'b0);
        send_frame(8'h0F, 16, 0, 0, 1'b0, 1'b0);
        send_frame(8'hF0, 16, 0, 0, 1'b0, 1'b0);
        idle(40);

        // Reset during data bits of 0xFF discards the partial word
        prescaler_config = 16'd16;
        parity_config    = 3'd0;
        stop_bits_config = 1'b0;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 16);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(negedge aclk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int i = 0; i < 6; i++) drive_bit(1'b1, 16);
        idle(20);
        send_frame(8'h3C, 16, 0, 0, 1'b0, 1'b0);
        idle(40);

        // Randomized frames across prescaler, parity and stop modes
        for (int f = 0; f < 25; f++) begin
            int p;
            p = int'($urandom_range(6, 20));
            send_frame(W'($urandom), p, int'($urandom_range(0, 4)), int'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            idle(p + 3);
        end
        idle(50);

        check("queue_drained", exp_q.size(), 32'd0);
        check("total_perr", seen_perr, exp_perr);
        check("total_ferr", seen_ferr, exp_ferr);
        check("total_ovr", seen_ovr, exp_ovr);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_PRESCALER, default 12, reset value of the bit period in aclk cycles.
REQ-002 Parameter PARITY, default 0, reset parity mode: 0 none, 1 even, 2 odd, 3 mark, 4 space.
REQ-003 Parameter WORD_SIZE, default 8, data bits per frame (5..9).
REQ-004 Parameter STOP_BITS, default 0, reset stop mode: 0 one, 1 two.
REQ-005 aclk, input, 1, the block's only clock; every register is clocked on its rising edge.
REQ-006 aresetn, input, 1, asynchronous active-low reset.
REQ-007 rxd, input, 1, asynchronous serial line, idle high.
REQ-008 rtsn, output, 1, request-to-send, active low.
REQ-009 m_axis_tdata, output, WORD_SIZE, received word, LSB first on line.
REQ-010 m_axis_tvalid / m_axis_tready, output / input, 1 each, AXI-Stream handshake.
REQ-011 busy, output, 1, high whenever the state is not IDLE.
REQ-012 parity_err / frame_err / overrun_err, output, 1 each, one-cycle error pulses.
REQ-013 prescaler_config (16), parity_config (3), stop_bits_config (1), inputs, runtime configuration.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value.
REQ-015 Configuration SHALL be latched from the *_config inputs on every cycle in IDLE and held constant for the rest of the frame.
REQ-016 A latched prescaler value P below 2 SHALL be treated as 2; H = P>>1.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP, DONE.
REQ-018 IDLE: a synchronized high-to-low transition SHALL cause entry to START, with the bit counter cleared.
REQ-019 START: after H cycles the line SHALL be sampled; a 0 sample enters DATA, and a 1 sample (glitch) returns to IDLE with no output and no error.
REQ-020 DATA: a sample SHALL be taken every P cycles, WORD_SIZE samples in total, shifted in LSB first.
REQ-021 Exit from DATA SHALL go to PARITY if parity is not none, and otherwise to STOP.
REQ-022 PARITY: the bit SHALL be sampled after P cycles; the expected value is the XOR of the data (even), its inverse (odd), 1 (mark) or 0 (space); a mismatch sets a pending parity flag.
REQ-023 STOP: one stop sample, or two for two-stop mode, SHALL be taken at P-cycle spacing; any 0 sample sets a pending framing flag; the last sample enters DONE.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-025 In DONE, if the output register is empty or is being drained this cycle (tvalid&&tready), the word SHALL be loaded and tvalid set on the next cycle.
REQ-026 In DONE, if the output register is full and not being drained, the new word SHALL be dropped and overrun_err pulsed.
REQ-027 In DONE, pending parity/frame flags SHALL pulse parity_err/frame_err for that one cycle and then clear.
REQ-028 A word with errors SHALL still be delivered.
REQ-029 m_axis_tvalid SHALL stay high, with tdata stable, until a cycle in which tready is high; it clears on the next edge unless it is reloaded in that same cycle.
REQ-030 Latency: tvalid SHALL rise on the edge following DONE, i.e. 2 cycles after the final stop sample.
REQ-031 A falling edge seen in DONE SHALL NOT be lost: a low synchronized line entering IDLE SHALL start a frame; back-to-back frames with a single stop bit are received.
REQ-032 rtsn SHALL equal m_axis_tvalid (deasserted while a word is unconsumed).
REQ-033 For WORD_SIZE < data register width, unused high bits of tdata SHALL be 0.

Reset
REQ-034 On aresetn low, asynchronously: state IDLE, m_axis_tvalid 0, m_axis_tdata 0, rtsn 0, busy 0, all error outputs 0, synchronizer 1, counters 0, configuration = parameter defaults.
REQ-035 Reset asserted mid-frame SHALL discard the partial word; after release the block SHALL wait for a new falling edge.

Verification
REQ-036 Scenario 8N1: P=16, send 0xA5 with tready=1 -> one tdata=0xA5 beat, no errors, busy low afterwards.
REQ-037 Scenario bad parity: even parity, 0x03 sent with parity bit 1 -> tdata=0x03, one parity_err pulse.
REQ-038 Scenario bad stop: 0x5A sent with stop bit 0 -> tdata=0x5A, one frame_err pulse; receiver resynchronizes on the next frame.
REQ-039 Scenario glitch: rxd low for 3 cycles with P=16 -> no tvalid, no error, returns to IDLE.
REQ-040 Scenario overrun: tready=0, send 0x11 then 0x22 -> tdata holds 0x11, one overrun_err pulse, rtsn high until the beat is consumed.
REQ-041 Scenario reset: aresetn pulsed during the DATA bits of 0xFF, then 0x3C sent -> only 0x3C delivered.
